icache_miss_ctrl: RTL and testbench

ICACHE_MISS_CTRL -- requirements
Module: icache_miss_ctrl

---
 rtl/sys_defs.sv | 44 ++++
 rtl/mshr_issue_fifo.sv | 63 ++++++
 rtl/icache_miss_ctrl.sv | 165 ++++++++++++++++
 tb/tb_icache_miss_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared memory-interface types and MSHR entry definitions for the icache miss path.
package sys_defs;

  localparam int unsigned ICACHE_MSHR_ENTRIES = 4;

  typedef logic [31:0] ADDR;
  typedef logic [3:0]  MEM_TAG;
  typedef logic [63:0] MEM_BLOCK;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'h0,
    MEM_LOAD  = 2'h1,
    MEM_STORE = 2'h2
  } MEM_COMMAND;

  typedef struct packed {
    logic valid;
    ADDR  addr;
  } I_ADDR;

  typedef struct packed {
    logic     valid;
    MEM_BLOCK data;
  } CACHE_DATA;

  typedef enum logic [1:0] {
    MSHR_EMPTY   = 2'h0,
    MSHR_PENDING = 2'h1,
    MSHR_ISSUED  = 2'h2,
    MSHR_FILL    = 2'h3
  } MSHR_STATE;

  typedef struct packed {
    MSHR_STATE state;
    ADDR       addr;
    MEM_TAG    tag;
    MEM_BLOCK  data;
  } MSHR_ENTRY;

  function automatic ADDR block_align(ADDR a);
    return {a[31:3], 3'b000};
  endfunction

endpackage

// File: rtl/mshr_issue_fifo.sv
// Circular FIFO of MSHR entry indices; head is the oldest entry still waiting to issue.
module mshr_issue_fifo #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned NUM_PUSH = 2,
  parameter int unsigned IDX_W    = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_PUSH-1:0]            push_valid,
  input  logic [NUM_PUSH-1:0][IDX_W-1:0] push_idx,
  input  logic                           pop,
  output logic                           empty,
  output logic [IDX_W-1:0]               head_idx
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][IDX_W-1:0] slot_q, slot_d;
  logic [PTR_W-1:0]            rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (cnt_q == '0);
  assign head_idx = slot_q[rd_q];

  // Pushes land in port order so allocation order is preserved within a cycle.
  always_comb begin
    slot_d = slot_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    if (pop && !empty) begin
      rd_d  = ptr_inc(rd_q);
      cnt_d = cnt_d - 1'b1;
    end
    for (int k = 0; k < int'(NUM_PUSH); k++) begin
      if (push_valid[k]) begin
        slot_d[wr_d] = push_idx[k];
        wr_d         = ptr_inc(wr_d);
        cnt_d        = cnt_d + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_q <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
    end else begin
      slot_q <= slot_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/icache_miss_ctrl.sv
// Icache miss handler: MSHR allocation/merge, FIFO-ordered memory issue, tagged fill return.
// Define ICACHE_PREFETCH_EN to also allocate a next-block (block+8) prefetch per new miss.
module icache_miss_ctrl
  import sys_defs::*;
#(
  parameter int unsigned MSHR_ENTRIES = ICACHE_MSHR_ENTRIES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] miss_valid,
  input  ADDR  [1:0] miss_addr,
  output logic       miss_ready,
  input  MEM_TAG     Imem2proc_transaction_tag,
  input  MEM_BLOCK   Imem2proc_data,
  input  MEM_TAG     Imem2proc_data_tag,
  output logic       mem_req_valid,
  output ADDR        mem_req_addr,
  output MEM_COMMAND mem_req_command,
  output logic       fill_valid,
  output I_ADDR      fill_addr,
  output CACHE_DATA  fill_data
);

  localparam int unsigned IDX_W = (MSHR_ENTRIES > 1) ? $clog2(MSHR_ENTRIES) : 1;
`ifdef ICACHE_PREFETCH_EN
  localparam int unsigned NUM_PUSH = 4;
`else
  localparam int unsigned NUM_PUSH = 2;
`endif

  MSHR_ENTRY [MSHR_ENTRIES-1:0]    mshr_q, mshr_d;
  logic [NUM_PUSH-1:0]             push_valid;
  logic [NUM_PUSH-1:0][IDX_W-1:0]  push_idx;
  logic                            issue_pop, fifo_empty;
  logic [IDX_W-1:0]                head_idx, alloc_slot, fill_idx;
  ADDR  [1:0]                      blk;
  logic [1:0]                      hit, need;
  logic [MSHR_ENTRIES-1:0]         avail, fill_mask;
  logic [IDX_W:0]                  n_empty;
`ifdef ICACHE_PREFETCH_EN
  ADDR                             pf_blk;
  logic                            pf_hit;
`endif

  function automatic logic [IDX_W-1:0] lowest(logic [MSHR_ENTRIES-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = int'(MSHR_ENTRIES) - 1; i >= 0; i--) begin
      if (m[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  mshr_issue_fifo #(
    .DEPTH    (MSHR_ENTRIES),
    .NUM_PUSH (NUM_PUSH),
    .IDX_W    (IDX_W)
  ) u_issue_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_valid (push_valid),
    .push_idx   (push_idx),
    .pop        (issue_pop),
    .empty      (fifo_empty),
    .head_idx   (head_idx)
  );

  always_comb begin
    mshr_d     = mshr_q;
    push_valid = '0;
    push_idx   = '0;
    alloc_slot = '0;
    n_empty    = '0;
    avail      = '0;
    fill_mask  = '0;
    hit        = '0;
    blk[0]     = block_align(miss_addr[0]);
    blk[1]     = block_align(miss_addr[1]);

    // A FILL entry still counts as tracked, so a miss on the block being filled merges.
    for (int i = 0; i < int'(MSHR_ENTRIES); i++) begin
      if (mshr_q[i].state == MSHR_EMPTY) begin
        avail[i] = 1'b1;
        n_empty  = n_empty + 1'b1;
      end else begin
        if (mshr_q[i].addr == blk[0]) hit[0] = 1'b1;
        if (mshr_q[i].addr == blk[1]) hit[1] = 1'b1;
      end
      if (mshr_q[i].state == MSHR_FILL) fill_mask[i] = 1'b1;
    end

    miss_ready = (n_empty >= (IDX_W + 1)'(2));
    need[0]    = miss_ready & miss_valid[0] & ~hit[0];
    need[1]    = miss_ready & miss_valid[1] & ~hit[1] & ~(miss_valid[0] & (blk[1] == blk[0]));

    mem_req_valid   = !fifo_empty;
    mem_req_addr    = mem_req_valid ? mshr_q[head_idx].addr : '0;
    mem_req_command = mem_req_valid ? MEM_LOAD : MEM_NONE;
    issue_pop       = mem_req_valid && (Imem2proc_transaction_tag != '0);
    if (issue_pop) begin
      mshr_d[head_idx].state = MSHR_ISSUED;
      mshr_d[head_idx].tag   = Imem2proc_transaction_tag;
    end

    if (Imem2proc_data_tag != '0) begin
      for (int i = 0; i < int'(MSHR_ENTRIES); i++) begin
        if (mshr_q[i].state == MSHR_ISSUED && mshr_q[i].tag == Imem2proc_data_tag) begin
          mshr_d[i].state = MSHR_FILL;
          mshr_d[i].data  = Imem2proc_data;
        end
      end
    end

    for (int p = 0; p < 2; p++) begin
      if (need[p]) begin
        alloc_slot        = lowest(avail);
        avail[alloc_slot] = 1'b0;
        mshr_d[alloc_slot] = '{state: MSHR_PENDING, addr: blk[p], tag: '0, data: '0};
        push_valid[p]     = 1'b1;
        push_idx[p]       = alloc_slot;
      end
    end

`ifdef ICACHE_PREFETCH_EN
    pf_blk = '0;
    pf_hit = 1'b0;
    for (int p = 0; p < 2; p++) begin
      if (need[p]) begin
        pf_blk = blk[p] + ADDR'(8);
        pf_hit = 1'b0;
        for (int i = 0; i < int'(MSHR_ENTRIES); i++) begin
          if (mshr_d[i].state != MSHR_EMPTY && mshr_d[i].addr == pf_blk) pf_hit = 1'b1;
        end
        if (avail != '0 && !pf_hit) begin
          alloc_slot         = lowest(avail);
          avail[alloc_slot]  = 1'b0;
          mshr_d[alloc_slot] = '{state: MSHR_PENDING, addr: pf_blk, tag: '0, data: '0};
          push_valid[2 + p]  = 1'b1;
          push_idx[2 + p]    = alloc_slot;
        end
      end
    end
`endif

    // Free last: allocation above must see the pre-free occupancy.
    fill_valid = |fill_mask;
    fill_idx   = lowest(fill_mask);
    fill_addr  = '0;
    fill_data  = '0;
    if (fill_valid) begin
      fill_addr              = '{valid: 1'b1, addr: mshr_q[fill_idx].addr};
      fill_data              = '{valid: 1'b1, data: mshr_q[fill_idx].data};
      mshr_d[fill_idx].state = MSHR_EMPTY;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mshr_q <= '0;
    end else begin
      mshr_q <= mshr_d;
    end
  end

endmodule

// File: tb/tb_icache_miss_ctrl.sv
// Randomized bench for icache_miss_ctrl against a slot/queue reference model of the miss rules.
module tb_icache_miss_ctrl;
  import sys_defs::*;

  localparam int N         = 4;
  localparam int S_EMPTY   = 0;
  localparam int S_PENDING = 1;
  localparam int S_ISSUED  = 2;
  localparam int S_FILL    = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] miss_valid;
  ADDR  [1:0] miss_addr;
  logic       miss_ready;
  MEM_TAG     ttag, dtag;
  MEM_BLOCK   ddata;
  logic       mem_req_valid;
  ADDR        mem_req_addr;
  MEM_COMMAND mem_req_command;
  logic       fill_valid;
  I_ADDR      fill_addr;
  CACHE_DATA  fill_data;

  always #5 clock = ~clock;

  icache_miss_ctrl #(.MSHR_ENTRIES(N)) dut (
    .clock                     (clock),
    .reset                     (reset),
    .miss_valid                (miss_valid),
    .miss_addr                 (miss_addr),
    .miss_ready                (miss_ready),
    .Imem2proc_transaction_tag (ttag),
    .Imem2proc_data            (ddata),
    .Imem2proc_data_tag        (dtag),
    .mem_req_valid             (mem_req_valid),
    .mem_req_addr              (mem_req_addr),
    .mem_req_command           (mem_req_command),
    .fill_valid                (fill_valid),
    .fill_addr                 (fill_addr),
    .fill_data                 (fill_data)
  );

  int          n_checks = 0;
  int          n_pass = 0;
  int          m_st[N];
  logic [31:0] m_addr[N];
  logic [3:0]  m_tag[N];
  logic [63:0] m_data[N];
  int          m_q[$];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_st[i] = S_EMPTY; m_addr[i] = '0; m_tag[i] = '0; m_data[i] = '0;
    end
    m_q.delete();
  endtask

  task automatic check_outputs();
    int ne, fs;
    ne = 0; fs = -1;
    for (int i = 0; i < N; i++) begin
      if (m_st[i] == S_EMPTY) ne++;
      if (m_st[i] == S_FILL && fs < 0) fs = i;
    end
    check_eq("miss_ready", miss_ready, ne >= 2);
    check_eq("req_valid", mem_req_valid, m_q.size() > 0);
    check_eq("req_cmd", mem_req_command, (m_q.size() > 0) ? MEM_LOAD : MEM_NONE);
    if (m_q.size() > 0) check_eq("req_addr", mem_req_addr, m_addr[m_q[0]]);
    check_eq("fill_valid", fill_valid, fs >= 0);
    check_eq("fill_addr_valid", fill_addr.valid, fs >= 0);
    check_eq("fill_data_valid", fill_data.valid, fs >= 0);
    if (fs >= 0) begin
      check_eq("fill_addr", fill_addr.addr, m_addr[fs]);
      check_eq("fill_data", fill_data.data, m_data[fs]);
    end
  endtask

  task automatic model_update(input logic [1:0] mv, input ADDR a0, input ADDR a1,
                              input MEM_TAG tt, input MEM_TAG dt, input MEM_BLOCK dd);
    int  fs, ne, s;
    bit  tracked;
    ADDR blk[2];
    fs = -1; ne = 0;
    blk[0] = a0 & ~32'h7;
    blk[1] = a1 & ~32'h7;
    for (int i = 0; i < N; i++) begin
      if (m_st[i] == S_EMPTY) ne++;
      else if (m_st[i] == S_FILL && fs < 0) fs = i;
    end
    if (dt != 0) begin
      for (int i = 0; i < N; i++)
        if (m_st[i] == S_ISSUED && m_tag[i] == dt) begin m_st[i] = S_FILL; m_data[i] = dd; end
    end
    if (m_q.size() > 0 && tt != 0) begin
      s = m_q.pop_front();
      m_st[s] = S_ISSUED; m_tag[s] = tt;
    end
    if (ne >= 2) begin
      for (int p = 0; p < 2; p++) begin
        if (mv[p]) begin
          tracked = 0;
          for (int i = 0; i < N; i++)
            if (m_st[i] != S_EMPTY && m_addr[i] == blk[p]) tracked = 1;
          if (!tracked) begin
            s = -1;
            for (int i = 0; i < N; i++) if (s < 0 && m_st[i] == S_EMPTY) s = i;
            m_st[s] = S_PENDING; m_addr[s] = blk[p]; m_q.push_back(s);
          end
        end
      end
    end
    if (fs >= 0) m_st[fs] = S_EMPTY;
  endtask

  task automatic step(input logic [1:0] mv, input ADDR a0, input ADDR a1,
                      input MEM_TAG tt, input MEM_TAG dt, input MEM_BLOCK dd);
    check_outputs();
    miss_valid = mv; miss_addr[0] = a0; miss_addr[1] = a1;
    ttag = tt; dtag = dt; ddata = dd;
    model_update(mv, a0, a1, tt, dt, dd);
    @(posedge clock);
    #1;
  endtask

  function automatic MEM_TAG free_tag();
    int     st;
    MEM_TAG t;
    bit     used;
    st = $urandom_range(0, 14);
    for (int k = 0; k < 15; k++) begin
      t = MEM_TAG'(((st + k) % 15) + 1);
      used = 0;
      for (int i = 0; i < N; i++) if (m_st[i] == S_ISSUED && m_tag[i] == t) used = 1;
      if (!used) return t;
    end
    return MEM_TAG'(1);
  endfunction

  function automatic ADDR rand_addr();
    return ADDR'(32'h1000 + ($urandom_range(0, 7) << 3) + $urandom_range(0, 7));
  endfunction

  task automatic auto_step(input logic [1:0] mv, input ADDR a0, input ADDR a1, input bit drain);
    MEM_TAG tt, dt;
    int     iss[$];
    tt = '0; dt = '0;
    if (m_q.size() > 0 && (drain || $urandom_range(0, 3) != 0)) tt = free_tag();
    for (int i = 0; i < N; i++) if (m_st[i] == S_ISSUED) iss.push_back(i);
    if (iss.size() > 0 && (drain || $urandom_range(0, 1) == 1))
      dt = m_tag[iss[$urandom_range(0, iss.size() - 1)]];
    else if ($urandom_range(0, 7) == 0)
      dt = free_tag();
    step(mv, a0, a1, tt, dt, {$urandom, $urandom});
  endtask

  task automatic drain();
    bit busy;
    for (int c = 0; c < 60; c++) begin
      busy = 0;
      for (int i = 0; i < N; i++) if (m_st[i] != S_EMPTY) busy = 1;
      if (!busy) break;
      auto_step(2'b00, '0, '0, 1'b1);
    end
  endtask

  task automatic reset_pulse();
    miss_valid = '0; ttag = '0; dtag = '0; ddata = '0;
    reset = 1'b1;
    #1;
    check_eq("rst_miss_ready", miss_ready, 1'b1);
    check_eq("rst_req_valid", mem_req_valid, 1'b0);
    check_eq("rst_req_cmd", mem_req_command, MEM_NONE);
    check_eq("rst_fill_valid", fill_valid, 1'b0);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; miss_valid = '0; miss_addr = '0; ttag = '0; dtag = '0; ddata = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset_pulse();
    @(posedge clock);
    #1;

    // single miss, tag 3, fill one cycle after data
    step(2'b01, 32'h100, 32'h0, 4'd0, 4'd0, 64'h0);
    step(2'b00, 32'h0, 32'h0, 4'd3, 4'd0, 64'h0);
    step(2'b00, 32'h0, 32'h0, 4'd0, 4'd3, 64'hDEAD_BEEF_0123_4567);
    step(2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 64'h0);
    step(2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 64'h0);

    // both ports on one block
    step(2'b11, 32'h104, 32'h100, 4'd0, 4'd0, 64'h0);
    step(2'b00, 32'h0, 32'h0, 4'd4, 4'd0, 64'h0);
    step(2'b00, 32'h0, 32'h0, 4'd0, 4'd4, 64'h1111_2222_3333_4444);
    step(2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 64'h0);
    step(2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 64'h0);

    // rejected twice, then tag 5
    step(2'b01, 32'h200, 32'h0, 4'd0, 4'd0, 64'h0);
    step(2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 64'h0);
    step(2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 64'h0);
    step(2'b00, 32'h0, 32'h0, 4'd5, 4'd0, 64'h0);
    step(2'b00, 32'h0, 32'h0, 4'd0, 4'd5, 64'h5555_AAAA_5555_AAAA);
    step(2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 64'h0);
    step(2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 64'h0);

    // capacity: four distinct blocks then back-pressure
    step(2'b11, 32'h300, 32'h340, 4'd0, 4'd0, 64'h0);
    step(2'b11, 32'h380, 32'h3c0, 4'd0, 4'd0, 64'h0);
    step(2'b11, 32'h400, 32'h440, 4'd0, 4'd0, 64'h0);
    step(2'b01, 32'h480, 32'h0, 4'd0, 4'd0, 64'h0);
    drain();

    // out-of-order return
    step(2'b11, 32'h500, 32'h540, 4'd0, 4'd0, 64'h0);
    step(2'b00, 32'h0, 32'h0, 4'd1, 4'd0, 64'h0);
    step(2'b00, 32'h0, 32'h0, 4'd2, 4'd0, 64'h0);
    step(2'b00, 32'h0, 32'h0, 4'd0, 4'd2, 64'h2222_0000_0000_0540);
    step(2'b00, 32'h0, 32'h0, 4'd0, 4'd1, 64'h1111_0000_0000_0500);
    step(2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 64'h0);
    step(2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 64'h0);

    // reset while ISSUED, stale data must not fill
    step(2'b01, 32'h600, 32'h0, 4'd0, 4'd0, 64'h0);
    step(2'b00, 32'h0, 32'h0, 4'd7, 4'd0, 64'h0);
    reset_pulse();
    step(2'b00, 32'h0, 32'h0, 4'd0, 4'd7, 64'h7777_7777_7777_7777);
    step(2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 64'h0);
    step(2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 64'h0);

    for (int it = 0; it < 400; it++) begin
      if (it == 200) reset_pulse();
      auto_step(2'($urandom_range(0, 3)), rand_addr(), rand_addr(), 1'b0);
    end
    drain();
    step(2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
